output_vc_status_tracker: RTL and testbench
===========================================

# output_vc_status_tracker

Tracks, per output VC of one router, the allocation state and the downstream credit count, and feeds availability and not-full status back to the combined VC/switch allocator. It sits between the allocator (which claims OVCs), the output crossbar/link (which consumes credits and releases OVCs on tail flits) and the downstream router's credit return path. It is the responder side of the allocator's OVC request/grant loop. All outputs derive from registers only; there is no combinational input-to-output path.

## Interface
- P, 5, router port count
- V, 4, VCs per port; PV = P*V
- B, 4, downstream buffer depth per VC in flits; CW = $clog2(B+1)
- VC_REALLOC_ATOMIC, "NO", "YES": a released OVC is reusable only after all B credits have returned
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- ovc_allocated_all  in  PV  pulse: OVC i claimed by the allocator this cycle
- flit_sent_all  in  PV  pulse: one flit sent on OVC i; consumes one credit
- tail_sent_all  in  PV  qualifies flit_sent_all[i]: the flit is a tail and releases OVC i
- credit_in_all  in  PV  pulse: downstream returned one credit for VC i
- ovc_avail_all  out  PV  OVC i may be granted by the VC allocator
- ovc_not_full_all  out  PV  credit[i] != 0
- ovc_nearly_full_all  out  PV  credit[i] <= 1
- credit_cnt_all  out  PV*CW  credit[i] in bits [i*CW +: CW]
- err_all  out  PV  sticky protocol-violation flag per OVC; cleared only by reset

## Operation
- Per-OVC state: FREE, BUSY, DRAIN. Reset: all FREE; credit = B; err = 0.
- FREE: ovc_allocated -> BUSY. If flit_sent & tail_sent arrive in the same cycle (single-flit packet), the OVC stays FREE, or goes to DRAIN when atomic mode is on.
- BUSY: flit_sent & tail_sent -> FREE when VC_REALLOC_ATOMIC="NO"; otherwise DRAIN when the next credit < B, and FREE when the next credit == B.
- DRAIN: next credit == B -> FREE. DRAIN is unreachable when VC_REALLOC_ATOMIC="NO".
- ovc_avail = (state == FREE) & ~ovc_allocated pulse pending. ovc_allocated registers into state, so avail drops on the cycle after the claim.
- Credit arithmetic: next = credit - flit_sent + credit_in, computed in CW+1 bits.
  - Simultaneous sent and credit_in: credit is unchanged.
  - Underflow (flit_sent with credit 0 and no credit_in): hold 0, set err.
  - Overflow (credit_in with credit B and no flit_sent): hold B, set err.
- Other err causes:
  - ovc_allocated while BUSY or DRAIN; state is unchanged.
  - tail_sent without flit_sent; the pulse is ignored.
  - flit_sent while FREE without same-cycle ovc_allocated; credit still decrements.

## Timing
- All updates occur on the rising clk edge. Every output reflects state one cycle after the causing input.
- Latency from ovc_allocated to ovc_avail low: 1 cycle. From tail to avail high: 1 cycle in non-atomic mode; in atomic mode, 1 cycle after the last credit returns.
- reset during a packet aborts it. All OVCs return to FREE with full credits on the next cycle, regardless of in-flight pulses sampled in that cycle.

## Structure
- Shared NoC package holds:
  - ovc_state_t enum {OVC_FREE, OVC_BUSY, OVC_DRAIN}, 2 bits
  - the CW derivation as a function of B
- One sub-module, ovc_status_slot, holds one OVC: state register, credit counter, err bit. It is instantiated PV times in a generate loop. The top level only slices and concatenates vectors.

## Test plan
- Reset, then idle 3 cycles:
  - all ovc_avail = 1, ovc_not_full = 1, credit = B = 4, err = 0.
- OVC 0: allocate at t0, then 4 flit_sent (last with tail), no credits:
  - avail[0] = 0 from t1
  - credit steps 4, 3, 2, 1, 0
  - nearly_full at credit 1; not_full = 0 at credit 0
  - non-atomic: avail[0] = 1 after the tail
- Atomic mode, same stimulus, then 4 credit_in pulses:
  - state is DRAIN after the tail and avail stays 0
  - avail rises 1 cycle after the 4th credit
- Same-cycle flit_sent + credit_in on OVC 3 at credit 2: credit stays 2.
- Same-cycle allocate + single-flit tail on FREE OVC 5 (non-atomic):
  - avail[5] stays high from the next cycle; credit = 3; err = 0.
- Violations, then reset:
  - credit_in at credit 4 -> credit holds 4, err = 1
  - second allocate while BUSY -> err = 1
  - reset mid-packet -> everything returns to reset values 1 cycle later

Source files
------------

// File: rtl/output_vc_status_tracker_pkg.sv
// rtl/output_vc_status_tracker_pkg.sv - shared NoC types and width helpers for OVC status tracking
package output_vc_status_tracker_pkg;

  // Per-OVC allocation state
  typedef enum logic [1:0] {
    OVC_FREE  = 2'd0,
    OVC_BUSY  = 2'd1,
    OVC_DRAIN = 2'd2
  } ovc_state_t;

  // Credit counter width: must hold the values 0..B inclusive
  function automatic int calc_cw(input int b);
    return $clog2(b + 1);
  endfunction

endpackage

// File: rtl/output_vc_status_tracker_slot.sv
// rtl/output_vc_status_tracker_slot.sv - one output VC: state, credit counter and sticky error bit
module ovc_status_slot
  import output_vc_status_tracker_pkg::*;
#(
  parameter int B      = 4,
  parameter int CW     = 3,
  parameter bit ATOMIC = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_alloc,
  input  logic          i_flit_sent,
  input  logic          i_tail_sent,
  input  logic          i_credit_in,
  output logic          o_avail,
  output logic          o_not_full,
  output logic          o_nearly_full,
  output logic [CW-1:0] o_credit,
  output logic          o_err
);

  localparam int unsigned FULL_I = B;
  localparam logic [CW:0] L_FULL_W = FULL_I[CW:0];
  localparam logic [CW-1:0] L_FULL = FULL_I[CW-1:0];

  ovc_state_t    r_state;
  logic [CW-1:0] r_credit;
  logic          r_err;

  logic [CW:0]   w_sum;
  logic          w_underflow;
  logic          w_overflow;
  logic [CW-1:0] w_credit_nxt;
  logic          w_tail;
  ovc_state_t    w_release_state;
  ovc_state_t    w_state_nxt;
  logic          w_err_set;

  // Credit arithmetic one bit wider than the counter so a wrap is visible; clamp and flag on violation
  always_comb begin
    w_sum        = {1'b0, r_credit} - {{CW{1'b0}}, i_flit_sent} + {{CW{1'b0}}, i_credit_in};
    w_underflow  = (r_credit == '0) && i_flit_sent && !i_credit_in;
    w_overflow   = (w_sum > L_FULL_W) && !w_underflow;
    w_credit_nxt = w_sum[CW-1:0];
    if (w_underflow) begin
      w_credit_nxt = '0;
    end else if (w_overflow) begin
      w_credit_nxt = L_FULL;
    end
  end

  // Next-state decode; a tail only counts when it qualifies a sent flit
  always_comb begin
    w_tail          = i_flit_sent && i_tail_sent;
    w_release_state = (ATOMIC && (w_credit_nxt != L_FULL)) ? OVC_DRAIN : OVC_FREE;
    w_state_nxt     = r_state;
    w_err_set       = w_underflow || w_overflow || (i_tail_sent && !i_flit_sent);
    case (r_state)
      OVC_FREE: begin
        if (i_alloc) begin
          w_state_nxt = w_tail ? w_release_state : OVC_BUSY;
        end else if (i_flit_sent) begin
          w_err_set = 1'b1;
        end
      end
      OVC_BUSY: begin
        if (i_alloc) begin
          w_err_set = 1'b1;
        end
        if (w_tail) begin
          w_state_nxt = w_release_state;
        end
      end
      OVC_DRAIN: begin
        if (i_alloc) begin
          w_err_set = 1'b1;
        end
        if (w_credit_nxt == L_FULL) begin
          w_state_nxt = OVC_FREE;
        end
      end
      default: w_state_nxt = OVC_FREE;
    endcase
  end

  // State, credit and sticky error registers; reset overrides any pulse in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= OVC_FREE;
      r_credit <= L_FULL;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_err    <= r_err | w_err_set;
    end
  end

  // Status outputs decode registers only, so no input reaches an output combinationally
  always_comb begin
    o_avail       = (r_state == OVC_FREE);
    o_not_full    = (r_credit != '0);
    o_nearly_full = (r_credit <= {{(CW-1){1'b0}}, 1'b1});
    o_credit      = r_credit;
    o_err         = r_err;
  end

endmodule

// File: rtl/output_vc_status_tracker.sv
// rtl/output_vc_status_tracker.sv - per-OVC allocation and credit status for one router's outputs
module output_vc_status_tracker
  import output_vc_status_tracker_pkg::*;
#(
  parameter int    P                 = 5,
  parameter int    V                 = 4,
  parameter int    B                 = 4,
  parameter string VC_REALLOC_ATOMIC = "NO",
  localparam int   PV                = P * V,
  localparam int   CW                = calc_cw(B)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [PV-1:0]    i_ovc_allocated_all,
  input  logic [PV-1:0]    i_flit_sent_all,
  input  logic [PV-1:0]    i_tail_sent_all,
  input  logic [PV-1:0]    i_credit_in_all,
  output logic [PV-1:0]    o_ovc_avail_all,
  output logic [PV-1:0]    o_ovc_not_full_all,
  output logic [PV-1:0]    o_ovc_nearly_full_all,
  output logic [PV*CW-1:0] o_credit_cnt_all,
  output logic [PV-1:0]    o_err_all
);

  localparam bit ATOMIC = (VC_REALLOC_ATOMIC == "YES");

  // One independent slot per output VC; the top only slices and concatenates
  for (genvar gi = 0; gi < PV; gi++) begin : g_slot
    ovc_status_slot #(
      .B      (B),
      .CW     (CW),
      .ATOMIC (ATOMIC)
    ) u_slot (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_alloc       (i_ovc_allocated_all[gi]),
      .i_flit_sent   (i_flit_sent_all[gi]),
      .i_tail_sent   (i_tail_sent_all[gi]),
      .i_credit_in   (i_credit_in_all[gi]),
      .o_avail       (o_ovc_avail_all[gi]),
      .o_not_full    (o_ovc_not_full_all[gi]),
      .o_nearly_full (o_ovc_nearly_full_all[gi]),
      .o_credit      (o_credit_cnt_all[gi*CW +: CW]),
      .o_err         (o_err_all[gi])
    );
  end

endmodule

// File: tb/tb_output_vc_status_tracker.sv
// tb/tb_output_vc_status_tracker.sv - directed self-checking bench for output_vc_status_tracker
module tb_output_vc_status_tracker;

  localparam int PV = 20;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [PV-1:0]   alloc = '0;
  logic [PV-1:0]   sent = '0;
  logic [PV-1:0]   tail = '0;
  logic [PV-1:0]   cin = '0;

  logic [PV-1:0]    avail_na, nf_na, nnf_na, err_na;
  logic [PV*CW-1:0] cred_na;
  logic [PV-1:0]    avail_at, nf_at, nnf_at, err_at;
  logic [PV*CW-1:0] cred_at;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  output_vc_status_tracker #(.P(5), .V(4), .B(4), .VC_REALLOC_ATOMIC("NO")) u_dut_na (
    .i_clk                 (clk),
    .i_reset               (rst),
    .i_ovc_allocated_all   (alloc),
    .i_flit_sent_all       (sent),
    .i_tail_sent_all       (tail),
    .i_credit_in_all       (cin),
    .o_ovc_avail_all       (avail_na),
    .o_ovc_not_full_all    (nf_na),
    .o_ovc_nearly_full_all (nnf_na),
    .o_credit_cnt_all      (cred_na),
    .o_err_all             (err_na)
  );

  output_vc_status_tracker #(.P(5), .V(4), .B(4), .VC_REALLOC_ATOMIC("YES")) u_dut_at (
    .i_clk                 (clk),
    .i_reset               (rst),
    .i_ovc_allocated_all   (alloc),
    .i_flit_sent_all       (sent),
    .i_tail_sent_all       (tail),
    .i_credit_in_all       (cin),
    .o_ovc_avail_all       (avail_at),
    .o_ovc_not_full_all    (nf_at),
    .o_ovc_nearly_full_all (nnf_at),
    .o_credit_cnt_all      (cred_at),
    .o_err_all             (err_at)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of pulses, let the edge sample them, then clear and settle past the edge
  task automatic cyc(input logic [PV-1:0] a, input logic [PV-1:0] s,
                     input logic [PV-1:0] t, input logic [PV-1:0] c);
    alloc = a; sent = s; tail = t; cin = c;
    @(posedge clk);
    #1;
    alloc = '0; sent = '0; tail = '0; cin = '0;
  endtask

  function automatic logic [CW-1:0] cr(input logic [PV*CW-1:0] v, input int i);
    return v[i*CW +: CW];
  endfunction

  task automatic check_reset_state(input string tag);
    logic [PV*CW-1:0] full;
    full = {PV{3'd4}};
    check({tag, "_avail_na"}, 64'(avail_na), 64'(20'hFFFFF));
    check({tag, "_avail_at"}, 64'(avail_at), 64'(20'hFFFFF));
    check({tag, "_notfull"}, 64'(nf_na), 64'(20'hFFFFF));
    check({tag, "_nearly"}, 64'(nnf_na), 64'(0));
    check({tag, "_credit_na"}, 64'(cred_na), 64'(full));
    check({tag, "_credit_at"}, 64'(cred_at), 64'(full));
    check({tag, "_err_na"}, 64'(err_na), 64'(0));
    check({tag, "_err_at"}, 64'(err_at), 64'(0));
  endtask

  logic [PV-1:0] b0, b3, b5, b7, b9, b10, b12, b1;

  initial begin
    b0 = 20'h1 << 0;  b1 = 20'h1 << 1;  b3 = 20'h1 << 3;  b5 = 20'h1 << 5;
    b7 = 20'h1 << 7;  b9 = 20'h1 << 9;  b10 = 20'h1 << 10; b12 = 20'h1 << 12;

    // Reset then idle 3 cycles
    rst = 1'b1;
    cyc('0, '0, '0, '0);
    cyc('0, '0, '0, '0);
    rst = 1'b0;
    repeat (3) cyc('0, '0, '0, '0);
    check_reset_state("rst");

    // OVC 0: allocate, then 3 body flits and a tail, no credits
    cyc(b0, '0, '0, '0);
    check("alloc_avail_na0", 64'(avail_na[0]), 64'(0));
    check("alloc_avail_at0", 64'(avail_at[0]), 64'(0));
    check("alloc_credit0", 64'(cr(cred_na, 0)), 64'(4));
    for (int k = 1; k <= 3; k++) begin
      cyc('0, b0, '0, '0);
      check($sformatf("body_credit0_%0d", k), 64'(cr(cred_na, 0)), 64'(4 - k));
      check($sformatf("body_avail0_%0d", k), 64'(avail_na[0]), 64'(0));
      check($sformatf("body_nearly0_%0d", k), 64'(nnf_na[0]), 64'(k == 3));
      check($sformatf("body_notfull0_%0d", k), 64'(nf_na[0]), 64'(1));
    end
    cyc('0, b0, b0, '0);
    check("tail_credit0", 64'(cr(cred_na, 0)), 64'(0));
    check("tail_notfull0", 64'(nf_na[0]), 64'(0));
    check("tail_nearly0", 64'(nnf_na[0]), 64'(1));
    check("tail_avail_na0", 64'(avail_na[0]), 64'(1));
    check("tail_avail_at0", 64'(avail_at[0]), 64'(0));
    check("tail_err_na", 64'(err_na), 64'(0));

    // Atomic: avail stays low while draining, rises after the 4th credit
    for (int k = 1; k <= 3; k++) begin
      cyc('0, '0, '0, b0);
      check($sformatf("drain_avail_at0_%0d", k), 64'(avail_at[0]), 64'(0));
      check($sformatf("drain_credit_at0_%0d", k), 64'(cr(cred_at, 0)), 64'(k));
    end
    cyc('0, '0, '0, b0);
    check("drain_done_avail_at0", 64'(avail_at[0]), 64'(1));
    check("drain_done_credit_at0", 64'(cr(cred_at, 0)), 64'(4));
    check("drain_done_credit_na0", 64'(cr(cred_na, 0)), 64'(4));
    check("drain_done_err_at", 64'(err_at), 64'(0));

    // OVC 3: bring credit to 2, then simultaneous sent + credit_in
    cyc(b3, '0, '0, '0);
    cyc('0, b3, '0, '0);
    cyc('0, b3, '0, '0);
    check("ovc3_credit2", 64'(cr(cred_na, 3)), 64'(2));
    cyc('0, b3, '0, b3);
    check("ovc3_same_cycle", 64'(cr(cred_na, 3)), 64'(2));
    cyc('0, '0, '0, b3);
    cyc('0, '0, '0, b3);
    check("ovc3_refill", 64'(cr(cred_na, 3)), 64'(4));

    // OVC 5: single-flit packet allocated and released in one cycle
    cyc(b5, b5, b5, '0);
    check("sf_avail_na5", 64'(avail_na[5]), 64'(1));
    check("sf_credit5", 64'(cr(cred_na, 5)), 64'(3));
    check("sf_err_na5", 64'(err_na[5]), 64'(0));
    check("sf_avail_at5", 64'(avail_at[5]), 64'(0));
    cyc('0, '0, '0, '0);
    check("sf_avail_na5_hold", 64'(avail_na[5]), 64'(1));
    cyc('0, '0, '0, b5);
    check("sf_avail_at5_free", 64'(avail_at[5]), 64'(1));
    check("sf_credit_at5", 64'(cr(cred_at, 5)), 64'(4));
    check("sf_err_all", 64'(err_na), 64'(0));

    // Violations
    cyc('0, '0, '0, b7);
    check("ovf_credit7", 64'(cr(cred_na, 7)), 64'(4));
    check("ovf_err7", 64'(err_na[7]), 64'(1));
    cyc(b3, '0, '0, '0);
    check("realloc_err3", 64'(err_na[3]), 64'(1));
    check("realloc_avail3", 64'(avail_na[3]), 64'(0));
    cyc('0, '0, b9, '0);
    check("lone_tail_err9", 64'(err_na[9]), 64'(1));
    check("lone_tail_avail9", 64'(avail_na[9]), 64'(1));
    cyc(b10, '0, '0, '0);
    repeat (5) cyc('0, b10, '0, '0);
    check("udf_credit10", 64'(cr(cred_na, 10)), 64'(0));
    check("udf_err10", 64'(err_na[10]), 64'(1));
    cyc('0, b12, '0, '0);
    check("free_flit_credit12", 64'(cr(cred_na, 12)), 64'(3));
    check("free_flit_err12", 64'(err_na[12]), 64'(1));
    check("err_vector", 64'(err_na), 64'(b3 | b7 | b9 | b10 | b12));

    // Reset mid-packet with pulses present in the reset cycle
    cyc(b1, '0, '0, '0);
    cyc('0, b1, '0, '0);
    rst = 1'b1;
    cyc(b0, b1, '0, b7);
    rst = 1'b0;
    check_reset_state("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound the run in case the stimulus process stalls
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
